// File: rtl/mk14_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module  : mk14_key_event_gen
// Brief   : Debounces a 32-bit key vector, queues press/release edges and
//           replays them as timed btn_dn / btn_up pulses for mk14_soc.
// Rev     : 1.0  initial release
// ============================================================================
module mk14_key_event_gen #(
    parameter int CLOCK_FREQ_MHZ = 12,
    parameter int DEBOUNCE_MSEC  = 5,
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] keys,
    output logic        btn_dn,
    output logic        btn_up,
    output logic [2:0]  btn_addr,
    output logic [2:0]  btn_bit,
    output logic        pending,
    output logic        overflow
);

    localparam int C_TICK_CYCLES = CLOCK_FREQ_MHZ * 1000 * DEBOUNCE_MSEC;
    localparam int C_TICK_W      = (C_TICK_CYCLES > 1) ? $clog2(C_TICK_CYCLES) : 1;
    localparam int C_AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int C_CNT_MAX     = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int C_CNT_W       = $clog2(C_CNT_MAX + 1);

    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(C_TICK_CYCLES - 1);
    localparam logic [C_TICK_W-1:0] C_TICK_ONE  = C_TICK_W'(1);
    localparam logic [C_AW:0]       C_PTR_ONE   = (C_AW + 1)'(1);
    localparam logic [C_CNT_W-1:0]  C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0]  C_PULSE_END = C_CNT_W'(PULSE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0]  C_GAP_END   = C_CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer and debounce
    // ------------------------------------------------------------------
    logic [31:0]         r_sync_meta;
    logic [31:0]         r_ks;
    logic [31:0]         r_samp;
    logic [31:0]         r_stable;
    logic [C_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;
    logic [31:0]         w_agree;

    assign w_tick  = (r_tick_cnt == C_TICK_LAST);
    assign w_agree = ~(r_ks ^ r_samp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= '0;
            r_ks        <= '0;
        end else begin
            r_sync_meta <= keys;
            r_ks        <= r_sync_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + C_TICK_ONE;
        end
    end

    // A bit only moves into stable when it matched the previous tick sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp   <= '0;
            r_stable <= '0;
        end else if (w_tick) begin
            r_samp   <= r_ks;
            r_stable <= (r_stable & ~w_agree) | (r_ks & w_agree);
        end
    end

    // ------------------------------------------------------------------
    // Edge scanner
    // ------------------------------------------------------------------
    logic [4:0]  r_p;
    logic [31:0] r_rep;
    logic        r_overflow;
    logic        w_edge;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic [5:0]  w_push_data;

    assign w_edge      = r_stable[r_p] ^ r_rep[r_p];
    assign w_push      = w_edge & ~w_full;
    assign w_push_data = {r_stable[r_p], r_p};

    // A blocked edge leaves rep untouched so the next visit retries it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p        <= '0;
            r_rep      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_p <= r_p + 5'd1;
            if (w_push) begin
                r_rep[r_p] <= r_stable[r_p];
            end
            if (w_edge && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [5:0]    r_mem [FIFO_DEPTH];
    logic [C_AW:0] r_wr_ptr;
    logic [C_AW:0] r_rd_ptr;
    logic [5:0]    w_rd_data;
    logic          w_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                       (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_rd_data = r_mem[r_rd_ptr[C_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic               w_cnt_clr;
    logic               r_type;
    logic [2:0]         r_addr;
    logic [2:0]         r_bit;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                if (r_cnt == C_PULSE_END) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == C_GAP_END) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_type  <= 1'b0;
            r_addr  <= 3'd0;
            r_bit   <= 3'd4;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_clr ? '0 : (r_cnt + C_CNT_ONE);
            // Address and bit only ever change on the IDLE->PULSE hand-off.
            if (w_pop) begin
                r_type <= w_rd_data[5];
                r_addr <= w_rd_data[4:2];
                r_bit  <= {1'b1, w_rd_data[1:0]};
            end
        end
    end

    assign btn_dn   = (r_state == S_PULSE) &  r_type;
    assign btn_up   = (r_state == S_PULSE) & ~r_type;
    assign btn_addr = r_addr;
    assign btn_bit  = r_bit;
    assign pending  = ~w_empty | (r_state != S_IDLE);
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mk14_key_event_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_mk14_key_event_gen
// Brief   : Directed self-checking bench for mk14_key_event_gen.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mk14_key_event_gen;

    logic        clk;
    logic        rst;
    logic [31:0] keys;
    logic        btn_dn;
    logic        btn_up;
    logic [2:0]  btn_addr;
    logic [2:0]  btn_bit;
    logic        pending;
    logic        overflow;

    mk14_key_event_gen #(
        .CLOCK_FREQ_MHZ (1),
        .DEBOUNCE_MSEC  (1),
        .PULSE_CYCLES   (4),
        .GAP_CYCLES     (4),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keys     (keys),
        .btn_dn   (btn_dn),
        .btn_up   (btn_up),
        .btn_addr (btn_addr),
        .btn_bit  (btn_bit),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Cycle index since the last reset, matching the DUT's free-running counters.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Event monitor
    logic       mon_clr;
    int         dn_cnt [32];
    int         up_cnt [32];
    int         dn_t   [32];
    int         up_t   [32];
    int         ncyc     = 0;
    int         run_len  = 0;
    int         last_len = 0;
    bit         both_high;
    bit         addr_moved;
    bit         pend_seen;
    bit         prev_act = 1'b0;
    logic [4:0] run_idx  = '0;
    logic [5:0] ev_q [$];

    always @(negedge clk) begin
        ncyc++;
        if (mon_clr) begin
            for (int i = 0; i < 32; i++) begin
                dn_cnt[i] = 0;
                up_cnt[i] = 0;
                dn_t[i]   = 0;
                up_t[i]   = 0;
            end
            last_len   = 0;
            both_high  = 1'b0;
            addr_moved = 1'b0;
            pend_seen  = 1'b0;
            ev_q.delete();
        end else begin
            if (pending) pend_seen = 1'b1;
            if (btn_dn && btn_up) both_high = 1'b1;
            if ((btn_dn || btn_up) && !prev_act) begin
                run_idx = {btn_addr, btn_bit[1:0]};
                if (btn_dn) begin
                    dn_cnt[run_idx]++;
                    dn_t[run_idx] = ncyc;
                end else begin
                    up_cnt[run_idx]++;
                    up_t[run_idx] = ncyc;
                end
                ev_q.push_back({btn_dn, run_idx});
            end else if ((btn_dn || btn_up) && ({btn_addr, btn_bit[1:0]} != run_idx)) begin
                addr_moved = 1'b1;
            end
        end
        if (btn_dn || btn_up) begin
            run_len++;
        end else begin
            if (prev_act) last_len = run_len;
            run_len = 0;
        end
        prev_act = btn_dn || btn_up;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 = btn_dn high, 1 = btn_up high, 2 = fully idle
    task automatic wait_sig(input int which, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step(1);
            if ((which == 0 && btn_dn) || (which == 1 && btn_up) ||
                (which == 2 && !pending && !btn_dn && !btn_up)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step(1);
        mon_clr = 1'b0;
    endtask

    function automatic logic [31:0] ev_at(input int i);
        return (i < ev_q.size()) ? 32'(ev_q[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;

        keys    = '0;
        rst     = 1'b1;
        mon_clr = 1'b1;
        step(3);
        chk("reset_btn_dn",   32'(btn_dn),   32'd0);
        chk("reset_btn_up",   32'(btn_up),   32'd0);
        chk("reset_btn_addr", 32'(btn_addr), 32'd0);
        chk("reset_btn_bit",  32'(btn_bit),  32'd4);
        chk("reset_pending",  32'(pending),  32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        clear_mon();

        // Single press and release of key 9 (addr 2, bit 5)
        keys[9] = 1'b1;
        wait_sig(0, 2040, ok);
        chk("press9_seen", 32'(ok),       32'd1);
        chk("press9_addr", 32'(btn_addr), 32'd2);
        chk("press9_bit",  32'(btn_bit),  32'd5);
        step(1000);
        chk("press9_len",   32'(last_len),    32'd4);
        chk("press9_count", 32'(dn_cnt[9]),   32'd1);
        chk("press9_total", 32'(ev_q.size()), 32'd1);
        keys[9] = 1'b0;
        wait_sig(1, 2040, ok);
        chk("rel9_seen", 32'(ok),       32'd1);
        chk("rel9_addr", 32'(btn_addr), 32'd2);
        chk("rel9_bit",  32'(btn_bit),  32'd5);
        step(20);
        chk("rel9_len",     32'(last_len),   32'd4);
        chk("rel9_count",   32'(up_cnt[9]),  32'd1);
        chk("rel9_overlap", 32'(both_high),  32'd0);
        chk("rel9_moved",   32'(addr_moved), 32'd0);

        // Glitch on key 3 lying entirely between two ticks
        clear_mon();
        for (int i = 0; i < 1100 && (cyc % 1000) != 250; i++) step(1);
        keys[3] = 1'b1;
        step(500);
        keys[3] = 1'b0;
        step(2100);
        chk("glitch_dn",      32'(dn_cnt[3]), 32'd0);
        chk("glitch_up",      32'(up_cnt[3]), 32'd0);
        chk("glitch_pending", 32'(pend_seen), 32'd0);

        // Keys 3 and 4 rise together
        clear_mon();
        keys = 32'h0000_0018;
        wait_sig(0, 2100, ok);
        chk("multi_seen", 32'(ok), 32'd1);
        step(40);
        chk("multi_count",   32'(ev_q.size()), 32'd2);
        chk("multi_first",   ev_at(0), 32'h23);
        chk("multi_second",  ev_at(1), 32'h24);
        chk("multi_spacing", 32'((dn_t[4] - dn_t[3]) >= 9), 32'd1);
        chk("multi_overlap", 32'(both_high), 32'd0);
        chk("multi_len",     32'(last_len),  32'd4);
        chk("multi_addr",    32'(btn_addr),  32'd1);
        chk("multi_bit",     32'(btn_bit),   32'd4);
        keys = '0;
        step(2100);
        wait_sig(2, 200, ok);
        chk("multi_drain", 32'(ok),        32'd1);
        chk("multi_up3",   32'(up_cnt[3]), 32'd1);
        chk("multi_up4",   32'(up_cnt[4]), 32'd1);

        // Overflow: keys 18..29 all become stable at cycle 2000, pointer at 16
        keys = '0;
        rst  = 1'b1;
        step(2);
        rst = 1'b0;
        clear_mon();
        for (int i = 0; i < 200 && cyc != 100; i++) step(1);
        keys = 32'h3FFC_0000;
        step(2300);
        wait_sig(2, 300, ok);
        chk("ovf_drain", 32'(ok),       32'd1);
        chk("ovf_flag",  32'(overflow), 32'd1);
        for (int k = 18; k <= 29; k++) begin
            chk($sformatf("ovf_once_%0d", k), 32'(dn_cnt[k]), 32'd1);
        end
        chk("ovf_total",   32'(ev_q.size()), 32'd12);
        chk("ovf_order9",  ev_at(9),  32'h3D);
        chk("ovf_order10", ev_at(10), 32'h3B);
        chk("ovf_order11", ev_at(11), 32'h3C);
        chk("ovf_overlap", 32'(both_high), 32'd0);

        // Reset during a press pulse of key 5, key kept held
        keys = '0;
        rst  = 1'b1;
        step(2);
        rst  = 1'b0;
        keys = 32'h0000_0020;
        clear_mon();
        wait_sig(0, 2100, ok);
        chk("rstp_first_seen", 32'(ok), 32'd1);
        step(1);
        rst = 1'b1;
        step(1);
        chk("rstp_btn_dn",   32'(btn_dn),   32'd0);
        chk("rstp_pending",  32'(pending),  32'd0);
        chk("rstp_addr",     32'(btn_addr), 32'd0);
        chk("rstp_bit",      32'(btn_bit),  32'd4);
        chk("rstp_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        clear_mon();
        step(1500);
        chk("rstp_no_early", 32'(dn_cnt[5]), 32'd0);
        wait_sig(0, 700, ok);
        chk("rstp_repress", 32'(ok),       32'd1);
        chk("rstp_addr2",   32'(btn_addr), 32'd1);
        chk("rstp_bit2",    32'(btn_bit),  32'd5);

        // Press then release of key 0
        keys = '0;
        step(2100);
        wait_sig(2, 200, ok);
        clear_mon();
        keys[0] = 1'b1;
        step(2500);
        keys[0] = 1'b0;
        step(2100);
        wait_sig(2, 200, ok);
        chk("order_drain",   32'(ok),        32'd1);
        chk("order_dn",      32'(dn_cnt[0]), 32'd1);
        chk("order_up",      32'(up_cnt[0]), 32'd1);
        chk("order_before",  32'(dn_t[0] < up_t[0]), 32'd1);
        chk("order_overlap", 32'(both_high), 32'd0);
        chk("order_ev0",     ev_at(0), 32'h20);
        chk("order_ev1",     ev_at(1), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mk14_key_event_gen.md
# mk14_key_event_gen

Key-event producer for the MK14 SoC keyboard interface. It samples a 32-bit raw key-state vector from a board key source, such as a LED&KEY scan result or GPIO matrix. It debounces the vector, detects press and release edges, queues the events, and replays them as timed `btn_dn` / `btn_up` pulses carrying `btn_addr` / `btn_bit`. It sits in front of `mk14_soc` and replaces bench-driven button stimulus with real hardware input.

## Interface
Parameters:
- `CLOCK_FREQ_MHZ`, 12: system clock frequency, used to derive the debounce tick.
- `DEBOUNCE_MSEC`, 5: debounce sample period. `TICK_CYCLES = CLOCK_FREQ_MHZ*1000*DEBOUNCE_MSEC`.
- `PULSE_CYCLES`, 4: cycles that `btn_dn` / `btn_up` stay high per event (≥1).
- `GAP_CYCLES`, 4: idle cycles after each pulse before the next event (≥1).
- `FIFO_DEPTH`, 8: event queue depth (power of 2).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock domain; `rst` is synchronous and active-high.
- `keys`  in  32  raw key levels, asynchronous, 1 = pressed. Index k maps to `btn_addr = k[4:2]` and `btn_bit = 4 + k[1:0]`.
- `btn_dn`  out  1  press pulse.
- `btn_up`  out  1  release pulse.
- `btn_addr`  out  3  digit/column of the current event.
- `btn_bit`  out  3  row bit (4..7) of the current event.
- `pending`  out  1  high while the FIFO is non-empty or the output FSM is not IDLE.
- `overflow`  out  1  sticky; set when an edge is detected while the FIFO is full. Cleared only by `rst`.

## Operation
- Synchronizer: 2-FF on every `keys` bit, giving `ks`.
- Debounce:
  - A free-running counter emits `tick` once every TICK_CYCLES cycles.
  - On `tick`: `samp <= ks`. For each bit where `ks == samp`, `stable <= ks`.
  - A bit must therefore agree on two consecutive ticks to change `stable`.
- Edge scanner:
  - A 5-bit pointer `p` increments every cycle and wraps 31→0.
  - If `stable[p] != rep[p]` and the FIFO is not full: push `{stable[p], p}` and set `rep[p] <= stable[p]`.
  - If the FIFO is full: no push, `rep` unchanged, and `overflow` is set. The edge is retried on the next visit, so no event is lost, only delayed.
- FIFO: entries are `{type, idx[4:0]}`, where type 1 = press and 0 = release. A push is blocked when full, even if a pop occurs in the same cycle.
- Output FSM with states IDLE, PULSE, GAP:
  - IDLE: if the FIFO is non-empty, pop, latch `btn_addr` / `btn_bit` from idx, and go to PULSE.
  - PULSE: `btn_dn = type`, `btn_up = ~type`, for PULSE_CYCLES cycles, then go to GAP.
  - GAP: both pulses low, `btn_addr` / `btn_bit` held, for GAP_CYCLES cycles, then go to IDLE.
- `btn_dn` and `btn_up` are never high together. `btn_addr` / `btn_bit` change only on the IDLE→PULSE transition.
- Event order is scanner visit order, starting from the current `p`. A press and a release of the same key always appear in chronological order, because `rep` toggles once per visit.

## Timing
- Reset values:
  - All outputs 0, except `btn_bit = 4`.
  - `samp`, `stable`, `rep`, the FIFO, `p`, and the tick counter all 0.
  - FSM in IDLE.
- Reset mid-operation: outputs take their reset values on the next cycle and queued events are discarded. Keys still held generate fresh press events after the debounce period, because `rep` is cleared.
- Latency from a `keys` change to `btn_dn` rising:
  - 2 cycles (sync).
  - Up to 2·TICK_CYCLES (debounce).
  - Up to 32 cycles (scan).
  - 1 cycle push→pop.
  - 1 cycle pop→pulse, plus queue wait.
- Event period: PULSE_CYCLES + GAP_CYCLES + 1 cycles per event.
- A glitch shorter than one tick interval never reaches `stable`.
- A key held across reset is treated as a new press.

## Test plan
All scenarios use `CLOCK_FREQ_MHZ=1`, `DEBOUNCE_MSEC=1` (TICK_CYCLES=1000), `PULSE_CYCLES=4`, `GAP_CYCLES=4`, `FIFO_DEPTH=8`.

- Press: `keys[9]=1` held for 3000 cycles → exactly one 4-cycle `btn_dn` with addr=2, bit=5, within 2040 cycles. Then release → one 4-cycle `btn_up` with addr=2, bit=5.
- Glitch reject: `keys[3]=1` for 500 cycles placed between ticks → no `btn_dn` or `btn_up`, and `pending` stays 0.
- Multi-key: `keys[3]` and `keys[4]` rise in the same cycle → two `btn_dn` events, addr0/bit7 and addr1/bit4, in scan order from `p`, separated by ≥9 cycles, with no overlap.
- Overflow:
  - Setup: force the FSM busy, then toggle 12 keys → FIFO fills at 8 and `overflow=1`.
  - Required: all 12 press events are eventually emitted, each exactly once.
- Reset mid-pulse: `rst` asserted during `btn_dn` → next cycle `btn_dn=0` and `pending=0`. With the key still held, a new `btn_dn` follows after debounce.
- Press-release order: `keys[0]` pressed for 2500 cycles, then released → `btn_dn` (addr0, bit4) strictly before `btn_up` (addr0, bit4), and both never high together.
